// File: rtl/vga_sync_monitor.sv
// VGA sink monitor: recovers pixel coordinates from hsync/vsync/blank_n, measures line/frame timing, reports lock.
// Optional per-frame CRC-16-CCITT of active pixels when VGA_MON_CRC_EN is defined.
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter bit SYNC_POL    = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_n,
  input  logic [7:0]  color_in,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  output logic [7:0]  pixel_color,
  output logic        frame_done,
  output logic        locked,
  output logic [10:0] h_total_meas,
  output logic [10:0] v_total_meas,
  output logic [7:0]  err_count
`ifdef VGA_MON_CRC_EN
  ,
  output logic [15:0] crc_out,
  output logic        crc_valid
`endif
);

  localparam logic [11:0] H_TOT    = 12'(H_TOTAL);
  localparam logic [11:0] V_TOT    = 12'(V_TOTAL);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] WD_LIMIT = 12'(2 * H_TOTAL);
  localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_r, hs_d, vs_r, vs_d, bl_r;
  logic [7:0]  col_r;
  logic [10:0] hcnt, vcnt, x_cnt, y_cnt;
  logic        line_act, fbad;
  logic [7:0]  good_q, good_d;
  logic        err_inc;
  logic        hs_lead, vs_lead, line_act_close, line_bad, frame_good, watchdog;
  logic [11:0] line_len, width, vcnt_close, lines_close;

  function automatic logic [10:0] sat11(input logic [11:0] v);
    return v[11] ? 11'h7FF : v[10:0];
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hs_r  <= 1'b0;
      hs_d  <= 1'b0;
      vs_r  <= 1'b0;
      vs_d  <= 1'b0;
      bl_r  <= 1'b0;
      col_r <= 8'd0;
    end else begin
      hs_r  <= hsync;
      hs_d  <= hs_r;
      vs_r  <= vsync;
      vs_d  <= vs_r;
      bl_r  <= blank_n;
      col_r <= color_in;
    end
  end

  // A pixel active on the same clock as an hsync edge still belongs to the closing line.
  assign hs_lead        = (hs_r == SYNC_POL) && (hs_d != SYNC_POL);
  assign vs_lead        = (vs_r == SYNC_POL) && (vs_d != SYNC_POL);
  assign line_len       = {1'b0, hcnt} + 12'd1;
  assign width          = {1'b0, x_cnt} + {11'd0, bl_r};
  assign line_act_close = line_act | bl_r;
  assign line_bad       = hs_lead && ((line_len != H_TOT) || (line_act_close && (width != H_ACT)));
  assign vcnt_close     = {1'b0, vcnt} + {11'd0, hs_lead};
  assign lines_close    = {1'b0, y_cnt} + {11'd0, hs_lead & line_act_close};
  assign frame_good     = !fbad && !line_bad && (vcnt_close == V_TOT) && (lines_close == V_ACT);
  assign watchdog       = !hs_lead && ({1'b0, hcnt} == WD_LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEARCH;
      good_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_inc = 1'b0;
    case (state_q)
      SEARCH: begin
        good_d = 8'd0;
        if (vs_lead) state_d = TRACK;
      end
      TRACK: begin
        if (watchdog) begin
          state_d = SEARCH;
          good_d  = 8'd0;
        end else if (vs_lead) begin
          if (frame_good) begin
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 >= LOCK_N) state_d = LOCKED;
          end else begin
            good_d = 8'd0;
          end
        end
      end
      LOCKED: begin
        if (watchdog || line_bad || (vs_lead && !frame_good)) begin
          state_d = SEARCH;
          good_d  = 8'd0;
          err_inc = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Line close is handled before frame close so a coincident hsync edge lands in the ending frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcnt         <= 11'd0;
      vcnt         <= 11'd0;
      x_cnt        <= 11'd0;
      y_cnt        <= 11'd0;
      line_act     <= 1'b0;
      fbad         <= 1'b0;
      h_total_meas <= 11'd0;
      v_total_meas <= 11'd0;
      err_count    <= 8'd0;
    end else begin
      if (hs_lead) begin
        h_total_meas <= sat11(line_len);
        hcnt         <= 11'd0;
        x_cnt        <= 11'd0;
        line_act     <= 1'b0;
        vcnt         <= sat11(vcnt_close);
        y_cnt        <= sat11(lines_close);
        if (line_bad) fbad <= 1'b1;
      end else begin
        hcnt <= sat11(line_len);
        if (bl_r) begin
          x_cnt    <= sat11({1'b0, x_cnt} + 12'd1);
          line_act <= 1'b1;
        end
      end
      if (vs_lead) begin
        v_total_meas <= sat11(vcnt_close);
        vcnt         <= 11'd0;
        y_cnt        <= 11'd0;
        fbad         <= 1'b0;
      end
      if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  assign pixel_x     = x_cnt[10] ? 10'd1023 : x_cnt[9:0];
  assign pixel_y     = y_cnt[10] ? 10'd1023 : y_cnt[9:0];
  assign locked      = (state_q == LOCKED);
  assign pixel_valid = bl_r & locked;
  assign pixel_color = col_r;
  assign frame_done  = vs_lead;

`ifdef VGA_MON_CRC_EN
  logic [15:0] crc_q, crc_upd;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign crc_upd   = bl_r ? crc16_byte(crc_q, col_r) : crc_q;
  assign crc_valid = vs_lead;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc_q   <= 16'hFFFF;
      crc_out <= 16'd0;
    end else if (vs_lead) begin
      crc_out <= crc_upd;
      crc_q   <= 16'hFFFF;
    end else begin
      crc_q <= crc_upd;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a reduced 40x20 raster (24x12 active) to keep runs short.
module tb_vga_sync_monitor;

  localparam int HT = 40;
  localparam int HA = 24;
  localparam int VT = 20;
  localparam int VA = 12;

  logic        clock = 1'b0;
  logic        reset_n, hsync, vsync, blank_n;
  logic [7:0]  color_in;
  logic [9:0]  pixel_x, pixel_y;
  logic        pixel_valid, frame_done, locked;
  logic [7:0]  pixel_color, err_count;
  logic [10:0] h_total_meas, v_total_meas;
`ifdef VGA_MON_CRC_EN
  logic [15:0] crc_out;
  logic        crc_valid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  vga_sync_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .hsync(hsync),
    .vsync(vsync),
    .blank_n(blank_n),
    .color_in(color_in),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .pixel_valid(pixel_valid),
    .pixel_color(pixel_color),
    .frame_done(frame_done),
    .locked(locked),
    .h_total_meas(h_total_meas),
    .v_total_meas(v_total_meas),
    .err_count(err_count)
`ifdef VGA_MON_CRC_EN
    ,
    .crc_out(crc_out),
    .crc_valid(crc_valid)
`endif
  );

  // Monitor: accumulates valid pixels and frame pulses; records first valid pixel after each arm.
  int         valid_total = 0;
  int         fd_total    = 0;
  int         crc_mis     = 0;
  int         arm_seq     = 0;
  int         seen_seq    = 0;
  logic [9:0] first_x = '0, first_y = '0, last_x = '0, last_y = '0;
  logic [7:0] first_c = '0, last_c = '0;

  always @(negedge clock) begin
    if (frame_done) fd_total <= fd_total + 1;
    if (pixel_valid) begin
      valid_total <= valid_total + 1;
      last_x      <= pixel_x;
      last_y      <= pixel_y;
      last_c      <= pixel_color;
      if (seen_seq != arm_seq) begin
        first_x  <= pixel_x;
        first_y  <= pixel_y;
        first_c  <= pixel_color;
        seen_seq <= arm_seq;
      end
    end
`ifdef VGA_MON_CRC_EN
    if (crc_valid !== frame_done) crc_mis <= crc_mis + 1;
`endif
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] pix_color(input int v, input int h);
`ifdef VGA_MON_CRC_EN
    return 8'hFF;
`else
    return {v[3:0], h[3:0]};
`endif
  endfunction

  // Hsync low for h 28..31, vsync low for lines 14..15, active region top-left.
  task automatic drive_line(input int v, input int len);
    for (int h = 0; h < len; h++) begin
      blank_n  = (h < HA) && (v < VA);
      hsync    = !((h >= 28) && (h < 32));
      vsync    = !((v >= 14) && (v < 16));
      color_in = blank_n ? pix_color(v, h) : 8'h00;
      tick();
    end
  endtask

  task automatic drive_frame(input int long_line);
    for (int v = 0; v < VT; v++) drive_line(v, (v == long_line) ? HT + 1 : HT);
  endtask

  task automatic idle(input int n);
    blank_n  = 1'b0;
    hsync    = 1'b1;
    vsync    = 1'b1;
    color_in = 8'h00;
    for (int i = 0; i < n; i++) tick();
  endtask

`ifdef VGA_MON_CRC_EN
  function automatic logic [15:0] crc_model(input int nbytes, input logic [7:0] b);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int n = 0; n < nbytes; n++) begin
      c = c ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction
`endif

  int v0, f0;

  initial begin
    reset_n  = 1'b0;
    hsync    = 1'b1;
    vsync    = 1'b1;
    blank_n  = 1'b0;
    color_in = 8'h00;
    tick();
    tick();
    check_output("rst_locked", 32'(locked), 0);
    check_output("rst_valid", 32'(pixel_valid), 0);
    check_output("rst_frame_done", 32'(frame_done), 0);
    check_output("rst_err", 32'(err_count), 0);
    check_output("rst_hmeas", 32'(h_total_meas), 0);
    check_output("rst_pixel_x", 32'(pixel_x), 0);
    reset_n = 1'b1;

    drive_frame(-1);
    drive_frame(-1);
    check_output("lock_after_2_edges", 32'(locked), 0);
    drive_frame(-1);
    check_output("lock_after_3_edges", 32'(locked), 1);
    check_output("h_total_meas", 32'(h_total_meas), HT);
    check_output("v_total_meas", 32'(v_total_meas), VT);
    check_output("err_clean", 32'(err_count), 0);

    v0 = valid_total;
    f0 = fd_total;
    arm_seq = arm_seq + 1;
    drive_frame(-1);
    check_output("valid_count", valid_total - v0, HA * VA);
    check_output("frame_done_count", fd_total - f0, 1);
    check_output("first_x", 32'(first_x), 0);
    check_output("first_y", 32'(first_y), 0);
    check_output("last_x", 32'(last_x), HA - 1);
    check_output("last_y", 32'(last_y), VA - 1);
    check_output("first_color", 32'(first_c), 32'(pix_color(0, 0)));
    check_output("last_color", 32'(last_c), 32'(pix_color(VA - 1, HA - 1)));

    drive_frame(3);
    check_output("long_line_unlock", 32'(locked), 0);
    check_output("long_line_err", 32'(err_count), 1);
    drive_frame(-1);
    check_output("relock_wait", 32'(locked), 0);
    drive_frame(-1);
    check_output("relock_2_frames", 32'(locked), 1);
    check_output("relock_err", 32'(err_count), 1);

    idle(60);
    check_output("wd_still_locked", 32'(locked), 1);
    idle(140);
    check_output("wd_unlock", 32'(locked), 0);
    check_output("wd_err", 32'(err_count), 2);

    drive_frame(-1);
    drive_frame(-1);
    drive_frame(-1);
    check_output("wd_relock", 32'(locked), 1);
    drive_line(0, 10);
    check_output("pre_rst_pixel_x", 32'(pixel_x), 9);
    reset_n = 1'b0;
    #2;
    check_output("async_rst_locked", 32'(locked), 0);
    check_output("async_rst_err", 32'(err_count), 0);
    check_output("async_rst_hmeas", 32'(h_total_meas), 0);
    check_output("async_rst_vmeas", 32'(v_total_meas), 0);
    check_output("async_rst_pixel_x", 32'(pixel_x), 0);
    check_output("async_rst_valid", 32'(pixel_valid), 0);
    check_output("async_rst_color", 32'(pixel_color), 0);
    tick();
    reset_n = 1'b1;

    drive_frame(-1);
    drive_frame(-1);
    check_output("post_rst_lock_2", 32'(locked), 0);
    drive_frame(-1);
    check_output("post_rst_lock_3", 32'(locked), 1);
    check_output("post_rst_err", 32'(err_count), 0);
    check_output("post_rst_hmeas", 32'(h_total_meas), HT);

`ifdef VGA_MON_CRC_EN
    check_output("crc_frame_a", 32'(crc_out), 32'(crc_model(HA * VA, 8'hFF)));
    drive_frame(-1);
    check_output("crc_frame_b", 32'(crc_out), 32'(crc_model(HA * VA, 8'hFF)));
    check_output("crc_valid_align", crc_mis, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
